vc_input_unit: RTL and testbench

- Switch input port holding VC_NUM virtual channels, each with its own circular FIFO, IDLE/WAITING/ACTIVE FSM and XY route computation.
- Generalises the single-VC buffer: writes are steered per VC, and a round-robin switch stage sends one flit per cycle from the ACTIVE VCs onto the shared crossbar input.
- Sits between the link input and the crossbar/VC allocator of a mesh router.

---
 rtl/vc_input_unit_if.sv | 40 ++++
 rtl/vc_input_unit.sv | 239 +++++++++++++++++++++++
 tb/tb_vc_input_unit.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/vc_input_unit_if.sv
// vc_input_unit_if: link-side write port, crossbar-side flit output and the
// per-VC flow-control signals of the VC input unit.
// err_o exists only when VC_ERR_FLAGS_EN is defined.
interface vc_input_unit_if #(
   parameter int VC_NUM = 2,
   parameter int FLIT_W = 10,
   parameter int OUT_M  = 5
);
   logic [FLIT_W-1:0]       data_i;
   logic                    wr_en_i;
   logic [VC_NUM-1:0]       wr_vc_i;
   logic [VC_NUM-1:0]       chan_alloc_i;
   logic [VC_NUM-1:0]       chan_rdy_i;
   logic [VC_NUM*OUT_M-1:0] req_o;
   logic [FLIT_W-1:0]       data_o;
   logic                    data_vld_o;
   logic [VC_NUM-1:0]       data_vc_o;
   logic [VC_NUM-1:0]       rdy_o;
`ifdef VC_ERR_FLAGS_EN
   logic [VC_NUM-1:0]       err_o;

   modport slave (
      input  data_i, wr_en_i, wr_vc_i, chan_alloc_i, chan_rdy_i,
      output req_o, data_o, data_vld_o, data_vc_o, rdy_o, err_o
   );
   modport master (
      output data_i, wr_en_i, wr_vc_i, chan_alloc_i, chan_rdy_i,
      input  req_o, data_o, data_vld_o, data_vc_o, rdy_o, err_o
   );
`else
   modport slave (
      input  data_i, wr_en_i, wr_vc_i, chan_alloc_i, chan_rdy_i,
      output req_o, data_o, data_vld_o, data_vc_o, rdy_o
   );
   modport master (
      output data_i, wr_en_i, wr_vc_i, chan_alloc_i, chan_rdy_i,
      input  req_o, data_o, data_vld_o, data_vc_o, rdy_o
   );
`endif
endinterface

// File: rtl/vc_input_unit.sv
// vc_input_unit: mesh-router input port with VC_NUM virtual channels. Each VC
// owns a FWFT circular FIFO, an IDLE/WAITING/ACTIVE FSM and an XY route
// computation; a round-robin switch stage forwards one flit per cycle from
// the ACTIVE VCs with one cycle of latency.
// Optional: define VC_ERR_FLAGS_EN to add sticky per-VC error flags (err_o).
module vc_input_unit #(
   parameter int VC_NUM      = 2,
   parameter int VC_DEPTH_W  = 2,
   parameter int FLIT_DATA_W = 8,
   parameter int FLIT_ID_W   = 2,
   parameter int COL_ADDR_W  = 2,
   parameter int ROW_ADDR_W  = 2,
   parameter int COL_CORD    = 1,
   parameter int ROW_CORD    = 1,
   parameter int OUT_M       = 5,
   parameter logic [FLIT_ID_W-1:0] HEADER_ID = 2'b10,
   parameter logic [FLIT_ID_W-1:0] TAIL_ID   = 2'b11
) (
   input logic            clk_i,
   input logic            rst_i,
   vc_input_unit_if.slave bus
);
   localparam int FLIT_W = FLIT_ID_W + FLIT_DATA_W;
   localparam int DEPTH  = 1 << VC_DEPTH_W;
   localparam int CNT_W  = VC_DEPTH_W + 1;
   localparam int PTR_W  = (VC_NUM > 1) ? $clog2(VC_NUM) : 1;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_WAITING = 2'd1,
      ST_ACTIVE  = 2'd2
   } vc_state_e;

   // XY dimension-order routing relative to this router's coordinates
   function automatic logic [OUT_M-1:0] xy_route(input logic [COL_ADDR_W-1:0] col,
                                                 input logic [ROW_ADDR_W-1:0] row);
      logic [OUT_M-1:0] r;
      r = '0;
      if (int'(col) > COL_CORD)      r[1] = 1'b1;
      else if (int'(col) < COL_CORD) r[3] = 1'b1;
      else if (int'(row) > ROW_CORD) r[2] = 1'b1;
      else if (int'(row) < ROW_CORD) r[0] = 1'b1;
      else                           r[4] = 1'b1;
      return r;
   endfunction

   function automatic logic is_onehot(input logic [VC_NUM-1:0] v);
      int n;
      n = 0;
      for (int i = 0; i < VC_NUM; i++) n += int'(v[i]);
      return (n == 1);
   endfunction

   function automatic logic [PTR_W-1:0] rr_idx(input logic [PTR_W-1:0] base, input int off);
      return PTR_W'((int'(base) + off) % VC_NUM);
   endfunction

   logic [FLIT_W-1:0]     mem_r     [VC_NUM][DEPTH];
   logic [VC_DEPTH_W-1:0] wr_ptr_r  [VC_NUM];
   logic [VC_DEPTH_W-1:0] rd_ptr_r  [VC_NUM];
   logic [CNT_W-1:0]      cnt_r     [VC_NUM];
   logic [CNT_W-1:0]      cnt_nxt_s [VC_NUM];
   logic [COL_ADDR_W-1:0] col_r     [VC_NUM];
   logic [COL_ADDR_W-1:0] col_nxt_s [VC_NUM];
   logic [ROW_ADDR_W-1:0] row_r     [VC_NUM];
   logic [ROW_ADDR_W-1:0] row_nxt_s [VC_NUM];
   logic [FLIT_W-1:0]     head_s    [VC_NUM];
   logic [FLIT_ID_W-1:0]  head_type_s [VC_NUM];
   vc_state_e             state_r     [VC_NUM];
   vc_state_e             state_nxt_s [VC_NUM];

   logic [VC_NUM-1:0]       empty_s, wr_acc_s, elig_s, gnt_s, pop_s, discard_s, latch_s;
   logic [VC_NUM-1:0]       rdy_r, vc_r;
   logic                    wr_ok_s, gnt_vld_s, vld_r;
   logic [PTR_W-1:0]        gnt_idx_s, arb_ptr_r;
   logic [VC_NUM*OUT_M-1:0] req_r, req_nxt_s;
   logic [FLIT_W-1:0]       data_r, data_nxt_s;

   // FIFO head view and write steering (a write needs a one-hot VC with room)
   always_comb begin
      wr_ok_s = bus.wr_en_i & is_onehot(bus.wr_vc_i);
      for (int v = 0; v < VC_NUM; v++) begin
         head_s[v]      = mem_r[v][rd_ptr_r[v]];
         head_type_s[v] = head_s[v][FLIT_W-1 -: FLIT_ID_W];
         empty_s[v]     = (cnt_r[v] == CNT_W'(0));
         wr_acc_s[v]    = wr_ok_s & bus.wr_vc_i[v] & rdy_r[v];
      end
   end

   // Round-robin switch arbiter over ACTIVE, non-empty, downstream-ready VCs
   always_comb begin
      gnt_vld_s = 1'b0;
      gnt_idx_s = '0;
      gnt_s     = '0;
      for (int v = 0; v < VC_NUM; v++) begin
         elig_s[v] = (state_r[v] == ST_ACTIVE) & ~empty_s[v] & bus.chan_rdy_i[v];
      end
      for (int k = 0; k < VC_NUM; k++) begin
         if (!gnt_vld_s && elig_s[rr_idx(arb_ptr_r, k)]) begin
            gnt_vld_s = 1'b1;
            gnt_idx_s = rr_idx(arb_ptr_r, k);
         end else begin
            gnt_vld_s = gnt_vld_s;
         end
      end
      gnt_s[gnt_idx_s] = gnt_vld_s;
      data_nxt_s       = gnt_vld_s ? head_s[gnt_idx_s] : '0;
   end

   // Per-VC FSM next state
   always_comb begin
      for (int v = 0; v < VC_NUM; v++) begin
         state_nxt_s[v] = state_r[v];
         case (state_r[v])
            ST_IDLE: begin
               if (!empty_s[v] && head_type_s[v] == HEADER_ID) state_nxt_s[v] = ST_WAITING;
               else                                            state_nxt_s[v] = ST_IDLE;
            end
            ST_WAITING: begin
               if (bus.chan_alloc_i[v]) state_nxt_s[v] = ST_ACTIVE;
               else                     state_nxt_s[v] = ST_WAITING;
            end
            ST_ACTIVE: begin
               if (gnt_s[v] && head_type_s[v] == TAIL_ID) state_nxt_s[v] = ST_IDLE;
               else                                      state_nxt_s[v] = ST_ACTIVE;
            end
            default: state_nxt_s[v] = ST_IDLE;
         endcase
      end
   end

   // Per-VC FSM outputs: pops, header latch, next route request
   always_comb begin
      pop_s     = '0;
      discard_s = '0;
      latch_s   = '0;
      req_nxt_s = '0;
      for (int v = 0; v < VC_NUM; v++) begin
         case (state_r[v])
            ST_IDLE: begin
               latch_s[v]   = ~empty_s[v] & (head_type_s[v] == HEADER_ID);
               discard_s[v] = ~empty_s[v] & (head_type_s[v] != HEADER_ID);
               pop_s[v]     = discard_s[v];
            end
            ST_ACTIVE: pop_s[v] = gnt_s[v];
            default:   pop_s[v] = 1'b0;
         endcase
         col_nxt_s[v] = latch_s[v] ? head_s[v][ROW_ADDR_W +: COL_ADDR_W] : col_r[v];
         row_nxt_s[v] = latch_s[v] ? head_s[v][0 +: ROW_ADDR_W] : row_r[v];
         cnt_nxt_s[v] = cnt_r[v] + CNT_W'(wr_acc_s[v]) - CNT_W'(pop_s[v]);
         if (state_nxt_s[v] == ST_WAITING) req_nxt_s[v*OUT_M +: OUT_M] = xy_route(col_nxt_s[v], row_nxt_s[v]);
         else                              req_nxt_s[v*OUT_M +: OUT_M] = '0;
      end
   end

   // FIFO storage: accepted flits land in the VC's tail slot (no reset needed)
   always_ff @(posedge clk_i) begin
      for (int v = 0; v < VC_NUM; v++) begin
         if (wr_acc_s[v]) mem_r[v][wr_ptr_r[v]] <= bus.data_i;
      end
   end

   // FSM state, FIFO pointers/occupancy and latched destination per VC
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int v = 0; v < VC_NUM; v++) begin
            state_r[v]  <= ST_IDLE;
            wr_ptr_r[v] <= '0;
            rd_ptr_r[v] <= '0;
            cnt_r[v]    <= '0;
            col_r[v]    <= '0;
            row_r[v]    <= '0;
         end
      end else begin
         for (int v = 0; v < VC_NUM; v++) begin
            state_r[v]  <= state_nxt_s[v];
            wr_ptr_r[v] <= wr_ptr_r[v] + VC_DEPTH_W'(wr_acc_s[v]);
            rd_ptr_r[v] <= rd_ptr_r[v] + VC_DEPTH_W'(pop_s[v]);
            cnt_r[v]    <= cnt_nxt_s[v];
            col_r[v]    <= col_nxt_s[v];
            row_r[v]    <= row_nxt_s[v];
         end
      end
   end

   // Registered outputs: switch stage, route requests, not-full flags, RR pointer
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         data_r    <= '0;
         vld_r     <= 1'b0;
         vc_r      <= '0;
         req_r     <= '0;
         rdy_r     <= '1;
         arb_ptr_r <= '0;
      end else begin
         data_r    <= data_nxt_s;
         vld_r     <= gnt_vld_s;
         vc_r      <= gnt_s;
         req_r     <= req_nxt_s;
         arb_ptr_r <= gnt_vld_s ? rr_idx(gnt_idx_s, 1) : arb_ptr_r;
         for (int v = 0; v < VC_NUM; v++) rdy_r[v] <= (cnt_nxt_s[v] != CNT_W'(DEPTH));
      end
   end

   assign bus.data_o     = data_r;
   assign bus.data_vld_o = vld_r;
   assign bus.data_vc_o  = vc_r;
   assign bus.req_o      = req_r;
   assign bus.rdy_o      = rdy_r;

`ifdef VC_ERR_FLAGS_EN
   logic [VC_NUM-1:0] first_r, err_r, drop_full_s, hdr_err_s;

   // Error sources: write to full VC, and a header popped mid-packet
   always_comb begin
      for (int v = 0; v < VC_NUM; v++) begin
         drop_full_s[v] = wr_ok_s & bus.wr_vc_i[v] & ~rdy_r[v];
         hdr_err_s[v]   = gnt_s[v] & ~first_r[v] & (head_type_s[v] == HEADER_ID);
      end
   end

   // First-flit marker per packet and sticky error flags
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         first_r <= '0;
         err_r   <= '0;
      end else begin
         for (int v = 0; v < VC_NUM; v++) begin
            if (state_r[v] == ST_WAITING && state_nxt_s[v] == ST_ACTIVE) first_r[v] <= 1'b1;
            else if (gnt_s[v])                                         first_r[v] <= 1'b0;
            else                                                       first_r[v] <= first_r[v];
         end
         err_r <= err_r | drop_full_s | discard_s | hdr_err_s;
      end
   end

   assign bus.err_o = err_r;
`endif
endmodule

// File: tb/tb_vc_input_unit.sv
// tb_vc_input_unit: directed scenarios plus randomized traffic, every cycle
// checked against a queue-based behavioural model of the input unit.
module tb_vc_input_unit;
   localparam int VC_NUM = 2;
   localparam int FLIT_W = 10;
   localparam int OUT_M  = 5;
   localparam int DEPTH  = 4;
   localparam int COL_CORD = 1;
   localparam int ROW_CORD = 1;
   localparam int M_IDLE = 0, M_WAIT = 1, M_ACT = 2;

   logic clk_i = 1'b0;
   logic rst_i;
   always #5 clk_i = ~clk_i;

   vc_input_unit_if #(.VC_NUM(VC_NUM), .FLIT_W(FLIT_W), .OUT_M(OUT_M)) bus ();
   vc_input_unit dut (.clk_i(clk_i), .rst_i(rst_i), .bus(bus.slave));

   int n_checks = 0;
   int n_errors = 0;

   // reference model state
   logic [FLIT_W-1:0]       mq [VC_NUM][$];
   int                      mst [VC_NUM];
   int                      mcol [VC_NUM];
   int                      mrow [VC_NUM];
   bit                      mfirst [VC_NUM];
   int                      rr;
   logic [FLIT_W-1:0]       exp_data;
   logic                    exp_vld;
   logic [VC_NUM-1:0]       exp_vc, exp_rdy, exp_err;
   logic [VC_NUM*OUT_M-1:0] exp_req;

   logic [FLIT_W-1:0] cap_data [$];
   logic [VC_NUM-1:0] cap_vc [$];

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic logic [OUT_M-1:0] xy(input int col, input int row);
      if (col > COL_CORD) return 5'b00010;
      if (col < COL_CORD) return 5'b01000;
      if (row > ROW_CORD) return 5'b00100;
      if (row < ROW_CORD) return 5'b00001;
      return 5'b10000;
   endfunction

   // advance the model by one clock using the inputs currently driven
   task automatic model_step();
      int g, idx;
      logic [FLIT_W-1:0] f;
      logic [1:0] ty;
      logic [VC_NUM-1:0] rdy_now;
      if (rst_i) begin
         for (int v = 0; v < VC_NUM; v++) begin
            mq[v].delete(); mst[v] = M_IDLE; mfirst[v] = 1'b0; mcol[v] = 0; mrow[v] = 0;
         end
         rr = 0; exp_data = '0; exp_vld = 1'b0; exp_vc = '0;
         exp_req = '0; exp_rdy = '1; exp_err = '0;
      end else begin
         g = -1;
         for (int v = 0; v < VC_NUM; v++) rdy_now[v] = (mq[v].size() < DEPTH);
         for (int k = 0; k < VC_NUM; k++) begin
            idx = (rr + k) % VC_NUM;
            if (g < 0 && mst[idx] == M_ACT && mq[idx].size() > 0 && bus.chan_rdy_i[idx]) g = idx;
         end
         exp_data = '0; exp_vld = 1'b0; exp_vc = '0;
         for (int v = 0; v < VC_NUM; v++) begin
            if (mst[v] == M_IDLE) begin
               if (mq[v].size() > 0) begin
                  f = mq[v][0];
                  ty = f[FLIT_W-1 -: 2];
                  if (ty == 2'b10) begin
                     mcol[v] = int'(f[3:2]); mrow[v] = int'(f[1:0]); mst[v] = M_WAIT;
                  end else begin
                     void'(mq[v].pop_front()); exp_err[v] = 1'b1;
                  end
               end
            end else if (mst[v] == M_WAIT) begin
               if (bus.chan_alloc_i[v]) begin mst[v] = M_ACT; mfirst[v] = 1'b1; end
            end else if (v == g) begin
               f = mq[v].pop_front();
               ty = f[FLIT_W-1 -: 2];
               exp_data = f; exp_vld = 1'b1; exp_vc[v] = 1'b1;
               if (ty == 2'b10 && !mfirst[v]) exp_err[v] = 1'b1;
               mfirst[v] = 1'b0;
               if (ty == 2'b11) mst[v] = M_IDLE;
               rr = (v + 1) % VC_NUM;
            end
         end
         if (bus.wr_en_i && $countones(bus.wr_vc_i) == 1) begin
            for (int v = 0; v < VC_NUM; v++) begin
               if (bus.wr_vc_i[v]) begin
                  if (rdy_now[v]) mq[v].push_back(bus.data_i);
                  else            exp_err[v] = 1'b1;
               end
            end
         end
         for (int v = 0; v < VC_NUM; v++) begin
            exp_rdy[v] = (mq[v].size() < DEPTH);
            exp_req[v*OUT_M +: OUT_M] = (mst[v] == M_WAIT) ? xy(mcol[v], mrow[v]) : '0;
         end
      end
   endtask

   task automatic tick();
      model_step();
      @(posedge clk_i);
      #1;
      check_eq("data_o", bus.data_o, exp_data);
      check_eq("data_vld_o", bus.data_vld_o, exp_vld);
      check_eq("data_vc_o", bus.data_vc_o, exp_vc);
      check_eq("req_o", bus.req_o, exp_req);
      check_eq("rdy_o", bus.rdy_o, exp_rdy);
`ifdef VC_ERR_FLAGS_EN
      check_eq("err_o", bus.err_o, exp_err);
`endif
      if (bus.data_vld_o) begin
         cap_data.push_back(bus.data_o);
         cap_vc.push_back(bus.data_vc_o);
      end
   endtask

   task automatic wr(input int vc, input logic [FLIT_W-1:0] d);
      bus.data_i = d; bus.wr_en_i = 1'b1; bus.wr_vc_i = '0; bus.wr_vc_i[vc] = 1'b1;
      tick();
      bus.wr_en_i = 1'b0;
   endtask

   logic [FLIT_W-1:0] exp_pkt [3] = '{10'h20D, 10'h101, 10'h302};
   logic [1:0] ty_r;

   initial begin
      rst_i = 1'b1;
      bus.data_i = '0; bus.wr_en_i = 1'b0; bus.wr_vc_i = '0;
      bus.chan_alloc_i = '0; bus.chan_rdy_i = '0;
      repeat (3) tick();
      rst_i = 1'b0;
      tick();
      check_eq("rst_rdy", bus.rdy_o, 2'b11);
      check_eq("rst_req", bus.req_o, 10'h000);
      check_eq("rst_vld", bus.data_vld_o, 1'b0);

      // head flit to VC0 -> WAITING with east request
      wr(0, 10'h20D);
      tick();
      check_eq("route_east_vc0", bus.req_o[4:0], 5'b00010);
      check_eq("route_vc1_zero", bus.req_o[9:5], 5'b00000);

      // complete the packet through the switch
      bus.chan_alloc_i = 2'b01; bus.chan_rdy_i = 2'b11;
      cap_data.delete(); cap_vc.delete();
      wr(0, 10'h101);
      wr(0, 10'h302);
      repeat (4) tick();
      check_eq("pkt_len", cap_data.size(), 3);
      for (int i = 0; i < 3 && i < cap_data.size(); i++) begin
         check_eq("pkt_data", cap_data[i], exp_pkt[i]);
         check_eq("pkt_vc", cap_vc[i], 2'b01);
      end
      check_eq("pkt_idle_req", bus.req_o, 10'h000);

      // two ACTIVE VCs interleave flit by flit
      bus.chan_alloc_i = 2'b11; bus.chan_rdy_i = 2'b00;
      wr(0, 10'h20D); wr(0, 10'h111); wr(0, 10'h312);
      wr(1, 10'h200); wr(1, 10'h121); wr(1, 10'h322);
      repeat (3) tick();
      bus.chan_rdy_i = 2'b11;
      cap_data.delete(); cap_vc.delete();
      repeat (6) tick();
      check_eq("rr_count", cap_vc.size(), 6);
      for (int i = 1; i < cap_vc.size(); i++) check_eq("rr_alternate", cap_vc[i] ^ cap_vc[i-1], 2'b11);
      bus.chan_alloc_i = 2'b00;
      tick();

      // fill VC1 and overflow it
      bus.chan_rdy_i = 2'b00;
      wr(1, 10'h205); wr(1, 10'h131); wr(1, 10'h132); wr(1, 10'h333);
      check_eq("full_rdy1", bus.rdy_o[1], 1'b0);
      wr(1, 10'h134);
      check_eq("drop_rdy1", bus.rdy_o[1], 1'b0);
`ifdef VC_ERR_FLAGS_EN
      check_eq("drop_err1", bus.err_o[1], 1'b1);
`endif
      bus.chan_alloc_i = 2'b10; bus.chan_rdy_i = 2'b11;
      cap_data.delete(); cap_vc.delete();
      repeat (8) tick();
      check_eq("drain_len", cap_data.size(), 4);
      if (cap_data.size() == 4) check_eq("drain_last", cap_data[3], 10'h333);
      bus.chan_alloc_i = 2'b00;

      // body flit into an IDLE VC is discarded
      wr(0, 10'h105);
      for (int i = 0; i < 3; i++) begin
         tick();
         check_eq("discard_req", bus.req_o, 10'h000);
         check_eq("discard_vld", bus.data_vld_o, 1'b0);
         check_eq("discard_rdy", bus.rdy_o, 2'b11);
      end

      // reset mid-packet, then a fresh head routes south
      wr(0, 10'h20D); wr(0, 10'h141); wr(0, 10'h142);
      rst_i = 1'b1;
      tick();
      rst_i = 1'b0;
      check_eq("mid_rst_rdy", bus.rdy_o, 2'b11);
      check_eq("mid_rst_vld", bus.data_vld_o, 1'b0);
      check_eq("mid_rst_req", bus.req_o, 10'h000);
      wr(0, 10'h207);
      tick();
      check_eq("post_rst_route", bus.req_o[4:0], 5'b00100);

      // randomized traffic
      for (int c = 0; c < 3000; c++) begin
         int r;
         rst_i = ($urandom_range(0, 499) == 0);
         bus.wr_en_i = ($urandom_range(0, 3) != 0);
         r = $urandom_range(0, 9);
         bus.wr_vc_i = (r == 0) ? 2'b00 : (r == 1) ? 2'b11 : (r < 6) ? 2'b01 : 2'b10;
         r = $urandom_range(0, 9);
         ty_r = (r < 3) ? 2'b10 : (r < 6) ? 2'b11 : 2'(r);
         bus.data_i = {ty_r, 8'($urandom)};
         bus.chan_alloc_i = 2'($urandom_range(0, 3));
         bus.chan_rdy_i = 2'($urandom_range(0, 3));
         tick();
      end
      rst_i = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
